writeback_stage: RTL and testbench

- Final pipeline stage, directly downstream of the data memory stage.
- Detects completion of the memory operation and captures the produced 16-bit `rdata`, which is either load data or the pass-through ALU result.
- Writes the captured value to the 8x16 register file owned by this block, which also provides the two decode read ports.
- Pulses `resetDataMemory` to re-arm the memory stage, then signals `writebackComplete` to fetch/control.

---
 rtl/writeback_stage.sv | 128 ++++++++++++
 tb/tb_writeback_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Final pipeline stage: captures the memory-stage result, writes it to the
// 8x16 register file, re-arms the memory stage and reports completion.
module writeback_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int ACK_CYCLES = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  memoryOperationComplete,
  input  logic [DATA_W-1:0]     rdata,
  input  logic                  regWrite,
  input  logic [REG_ADDR_W-1:0] writeReg,
  input  logic [REG_ADDR_W-1:0] readReg1,
  input  logic [REG_ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0]     rd1,
  output logic [DATA_W-1:0]     rd2,
  output logic                  resetDataMemory,
  output logic                  writebackComplete,
  output logic                  wbError
);

  localparam int NREG  = 1 << REG_ADDR_W;
  localparam int ACK_W = $clog2(ACK_CYCLES) + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    ACK,
    WAIT_CLR
  } state_t;

  state_t state;

  logic [DATA_W-1:0]     regs [NREG];
  logic [DATA_W-1:0]     cap_data;
  logic [REG_ADDR_W-1:0] cap_reg;
  logic                  cap_we;
  logic [ACK_W-1:0]      ack_cnt;
  logic [TO_W-1:0]       to_cnt;

  logic sync0;
  logic sync1;
  logic sync_prev;
  logic rise;

  // Reset to 1 so a level already high at reset release is not a new op.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync0     <= 1'b1;
      sync1     <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync0     <= memoryOperationComplete;
      sync1     <= sync0;
      sync_prev <= sync1;
    end
  end

  assign rise = sync1 & ~sync_prev;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state             <= IDLE;
      cap_data          <= '0;
      cap_reg           <= '0;
      cap_we            <= 1'b0;
      ack_cnt           <= '0;
      to_cnt            <= '0;
      resetDataMemory   <= 1'b0;
      writebackComplete <= 1'b0;
      wbError           <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      writebackComplete <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            cap_data <= rdata;
            cap_reg  <= writeReg;
            cap_we   <= regWrite;
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (cap_we && (cap_reg != '0)) begin
            regs[cap_reg] <= cap_data;
          end
          ack_cnt         <= ACK_W'(ACK_CYCLES - 1);
          resetDataMemory <= 1'b1;
          state           <= ACK;
        end
        ACK: begin
          if (ack_cnt != '0) begin
            ack_cnt <= ack_cnt - 1'b1;
          end else begin
            resetDataMemory <= 1'b0;
            to_cnt          <= '0;
            state           <= WAIT_CLR;
          end
        end
        WAIT_CLR: begin
          if (!sync1) begin
            writebackComplete <= 1'b1;
            state             <= IDLE;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            to_cnt            <= TO_W'(TIMEOUT);
            wbError           <= 1'b1;
            writebackComplete <= 1'b1;
            state             <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // R0 reads as zero regardless of array contents.
  assign rd1 = (readReg1 == '0) ? '0 : regs[readReg1];
  assign rd2 = (readReg2 == '0) ? '0 : regs[readReg2];

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized self-checking bench for writeback_stage against a
// cycle-count reference model of the write-back handshake.
module tb_writeback_stage;

  logic        clk;
  logic        resetN;
  logic        complete;
  logic [15:0] rdata;
  logic        regWrite;
  logic [2:0]  writeReg;
  logic [2:0]  readReg1;
  logic [2:0]  readReg2;
  logic [15:0] rd1;
  logic [15:0] rd2;
  logic        resetDataMemory;
  logic        writebackComplete;
  logic        wbError;

  int passed;
  int total;
  int cyc;

  logic [15:0] exp_regs [8];
  logic        exp_err;

  writeback_stage dut (
    .clk                     (clk),
    .resetN                  (resetN),
    .memoryOperationComplete (complete),
    .rdata                   (rdata),
    .regWrite                (regWrite),
    .writeReg                (writeReg),
    .readReg1                (readReg1),
    .readReg2                (readReg2),
    .rd1                     (rd1),
    .rd2                     (rd2),
    .resetDataMemory         (resetDataMemory),
    .writebackComplete       (writebackComplete),
    .wbError                 (wbError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One write-back operation. Memory drops complete so that edge E+dd
  // samples it low; dd > 18 means complete never drops (timeout).
  task automatic run_op(input logic [15:0] d, input logic [2:0] r,
                        input logic we, input int dd);
    int e;
    int w;
    int dgap;
    logic tmo;
    logic [15:0] old_v;
    logic [15:0] new_v;
    logic [15:0] exp_rd;
    logic e_rdm;
    logic e_wbc;
    logic e_err;
    complete = 1'b0;
    repeat (4) @(negedge clk);
    rdata    = d;
    writeReg = r;
    regWrite = we;
    readReg1 = r;
    readReg2 = r;
    complete = 1'b1;
    e     = cyc + 1;
    tmo   = (dd > 18);
    dgap  = dd + 2;
    if (dgap < 6) dgap = 6;
    w     = tmo ? e + 20 : e + dgap;
    old_v = exp_regs[r];
    new_v = (we && r != 3'd0) ? d : old_v;
    while (cyc < e + 24) begin
      @(negedge clk);
      if (cyc == e + dd - 1) complete = 1'b0;
      e_rdm  = (cyc == e + 3) || (cyc == e + 4);
      e_wbc  = (cyc == w);
      e_err  = exp_err || (tmo && cyc >= w);
      exp_rd = (cyc >= e + 3) ? new_v : old_v;
      total++;
      if (resetDataMemory !== e_rdm)
        $display("FAIL op_rdm cyc=%0d got %b expected %b",
                 cyc - e, resetDataMemory, e_rdm);
      else passed++;
      total++;
      if (writebackComplete !== e_wbc)
        $display("FAIL op_wbc cyc=%0d got %b expected %b",
                 cyc - e, writebackComplete, e_wbc);
      else passed++;
      total++;
      if (wbError !== e_err)
        $display("FAIL op_err cyc=%0d got %b expected %b",
                 cyc - e, wbError, e_err);
      else passed++;
      total++;
      if (rd1 !== exp_rd || rd2 !== exp_rd)
        $display("FAIL op_rd r%0d cyc=%0d got %h/%h expected %h",
                 r, cyc - e, rd1, rd2, exp_rd);
      else passed++;
      // Live inputs scrambled after capture must have no effect.
      if (cyc == e + 2) begin
        rdata    = 16'($urandom);
        writeReg = 3'($urandom);
        regWrite = ~we;
      end
    end
    exp_regs[r] = new_v;
    if (tmo) exp_err = 1'b1;
  endtask

  task automatic test_reset();
    resetN   = 1'b0;
    complete = 1'b1;
    rdata    = 16'hBEEF;
    writeReg = 3'd4;
    regWrite = 1'b1;
    readReg1 = 3'd0;
    readReg2 = 3'd0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) exp_regs[i] = 16'h0;
    exp_err = 1'b0;
    resetN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      readReg1 = 3'(i);
      readReg2 = 3'(7 - i);
      #1;
      total++;
      if (resetDataMemory !== 1'b0 || writebackComplete !== 1'b0 ||
          wbError !== 1'b0)
        $display("FAIL reset_ctl cyc=%0d got %b%b%b expected 000", i,
                 resetDataMemory, writebackComplete, wbError);
      else passed++;
      total++;
      if (rd1 !== 16'h0 || rd2 !== 16'h0)
        $display("FAIL reset_rd cyc=%0d got %h/%h expected 0000",
                 i, rd1, rd2);
      else passed++;
    end
    complete = 1'b0;
  endtask

  task automatic test_readback();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      readReg1 = 3'(i);
      readReg2 = 3'(7 - i);
      #1;
      total++;
      if (rd1 !== exp_regs[i] || rd2 !== exp_regs[7 - i])
        $display("FAIL readback r%0d got %h/%h expected %h/%h", i,
                 rd1, rd2, exp_regs[i], exp_regs[7 - i]);
      else passed++;
    end
  endtask

  task automatic test_directed();
    run_op(16'hA5C3, 3'd3, 1'b1, 4);
    run_op(16'hFFFF, 3'd0, 1'b1, 4);
    run_op(16'h1234, 3'd5, 1'b0, 4);
    test_readback();
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      run_op(16'($urandom), 3'($urandom), ($urandom % 4) != 0,
             $urandom_range(18, 4));
    end
    test_readback();
  endtask

  task automatic test_timeout();
    run_op(16'h5A5A, 3'd6, 1'b1, 100);
    // Complete still high: must not start another operation.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (resetDataMemory !== 1'b0 || writebackComplete !== 1'b0 ||
          wbError !== 1'b1)
        $display("FAIL timeout_hold cyc=%0d got %b%b%b expected 001", i,
                 resetDataMemory, writebackComplete, wbError);
      else passed++;
    end
    complete = 1'b0;
    run_op(16'h0042, 3'd1, 1'b1, 5);
    test_readback();
  endtask

  task automatic test_reset_mid_write();
    int e;
    complete = 1'b0;
    repeat (4) @(negedge clk);
    rdata    = 16'h0F0F;
    writeReg = 3'd2;
    regWrite = 1'b1;
    readReg1 = 3'd2;
    readReg2 = 3'd6;
    complete = 1'b1;
    e = cyc + 1;
    while (cyc < e + 2) @(negedge clk);
    resetN = 1'b0;
    for (int i = 0; i < 8; i++) exp_regs[i] = 16'h0;
    exp_err = 1'b0;
    #1;
    total++;
    if (resetDataMemory !== 1'b0 || writebackComplete !== 1'b0 ||
        wbError !== 1'b0)
      $display("FAIL midrst_ctl got %b%b%b expected 000",
               resetDataMemory, writebackComplete, wbError);
    else passed++;
    complete = 1'b0;
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (resetDataMemory !== 1'b0 || writebackComplete !== 1'b0 ||
          rd1 !== 16'h0)
        $display("FAIL midrst_after cyc=%0d got %b%b %h expected 00 0000",
                 i, resetDataMemory, writebackComplete, rd1);
      else passed++;
    end
    test_readback();
  endtask

  task automatic test_back_to_back();
    run_op(16'h1111, 3'd7, 1'b1, 4);
    run_op(16'h2222, 3'd7, 1'b1, 4);
    run_op(16'h3333, 3'd4, 1'b1, 18);
    test_readback();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_directed();
    test_random();
    test_timeout();
    test_reset_mid_write();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
